// File: rtl/axi4_stream_deframer.sv
// Purpose: hunts an AXI4-Stream for a 32-bit sync marker, strips it, forwards the next LEN words as one packet.
// Latency: 1 cycle from accepted payload word to m_tvalid; marker words are consumed and never forwarded.
// Backpressure: s_tready = !m_tvalid || m_tready; the single output register holds while m_tvalid && !m_tready.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   s_tdata/tvalid/tready/tlast   framed input stream
//   marker                32-bit sync marker, most-significant slice arrives first
//   m_tdata/tvalid/tready/tlast   payload output stream, m_tlast on final word of each frame
//   frame_err             one-cycle pulse when s_tlast cuts a frame short
module axi4_stream_deframer #(
  parameter int DATA_W = 8,
  parameter int LEN    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  input  logic [31:0]       marker,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              frame_err
);

  localparam int MARKER_WORDS = 32 / DATA_W;
  localparam int FW = $clog2(MARKER_WORDS + 1);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic {HUNT, PAYLOAD} state_t;

  state_t            state, state_n;
  logic [31:0]       hist, hist_n;
  logic [FW-1:0]     fill, fill_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] tdata_n;
  logic              tvalid_n, tlast_n, err_n;
  logic              acc;
  logic [31:0]       shifted;
  logic              match;

  assign s_tready = !m_tvalid || m_tready;
  assign acc      = s_tvalid && s_tready;

  // History holds the last MARKER_WORDS words; the oldest slice drops off the top
  // so the newest word always sits in the least-significant slice.
  assign shifted = 32'({hist, s_tdata});
  assign match   = (fill >= FW'(MARKER_WORDS - 1)) && (shifted == marker);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      hist      <= '0;
      fill      <= '0;
      cnt       <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      hist      <= hist_n;
      fill      <= fill_n;
      cnt       <= cnt_n;
      m_tdata   <= tdata_n;
      m_tvalid  <= tvalid_n;
      m_tlast   <= tlast_n;
      frame_err <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    hist_n   = hist;
    fill_n   = fill;
    cnt_n    = cnt;
    tdata_n  = m_tdata;
    // Output holds while stalled; otherwise it empties unless a new word loads below.
    tvalid_n = m_tvalid && !m_tready;
    tlast_n  = (m_tvalid && !m_tready) ? m_tlast : 1'b0;
    err_n    = 1'b0;

    case (state)
      HUNT: begin
        if (acc) begin
          hist_n = shifted;
          if (s_tlast) begin
            // A marker may not span packets.
            fill_n = '0;
          end else if (match) begin
            state_n = PAYLOAD;
            cnt_n   = '0;
            fill_n  = '0;
          end else if (fill != FW'(MARKER_WORDS)) begin
            fill_n = fill + 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (acc) begin
          tdata_n  = s_tdata;
          tvalid_n = 1'b1;
          if (cnt == CW'(LEN - 1)) begin
            tlast_n = 1'b1;
            state_n = HUNT;
            cnt_n   = '0;
          end else if (s_tlast) begin
            // Truncated frame: close it out early and flag it.
            tlast_n = 1'b1;
            err_n   = 1'b1;
            state_n = HUNT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

endmodule

// File: tb/tb_axi4_stream_deframer.sv
module tb_axi4_stream_deframer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tready;
  logic       s_tlast = 1'b0;
  logic [31:0] marker = 32'hFFFF_FFFF;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic       m_tlast;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  int err_cnt = 0;

  logic [7:0] out_data[$];
  logic       out_last[$];
  logic       out_err[$];
  int         out_cyc[$];

  axi4_stream_deframer #(.DATA_W(8), .LEN(4)) dut (
    .clk(clk), .reset(reset),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .marker(marker),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: mid-cycle, record every beat that will complete at the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) err_cnt = err_cnt + 1;
      if (m_tvalid && m_tready) begin
        out_data.push_back(m_tdata);
        out_last.push_back(m_tlast);
        out_err.push_back(frame_err);
        out_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_mon();
    out_data.delete(); out_last.delete(); out_err.delete(); out_cyc.delete();
    err_cnt = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = l;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!s_tready) begin
      errors++; checks++;
      $display("FAIL send_timeout: s_tready=%0b required 1", s_tready);
    end
    last_acc = cyc;
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_marker();
    for (int i = 0; i < 4; i++) send(8'hFF, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string name, input logic [7:0] exp[4]);
    checks++;
    if (out_data.size() !== 4) begin
      errors++;
      $display("FAIL %s_count: got %0d beats required 4", name, out_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_data[i] !== exp[i] || out_last[i] !== (i == 3)) begin
          errors++;
          $display("FAIL %s_beat%0d: data=%h last=%b required data=%h last=%b",
                   name, i, out_data[i], out_last[i], exp[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; #1;
    checks++;
    if ({m_tvalid, m_tlast, m_tdata, frame_err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: v=%b l=%b d=%h e=%b required all 0", m_tvalid, m_tlast, m_tdata, frame_err);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_tready: got %b required 1", s_tready);
    end
    @(negedge clk); reset = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    logic [7:0] exp[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int acc_c[4];
    clear_mon();
    send_marker();
    for (int i = 0; i < 4; i++) begin
      send(exp[i], 1'b0);
      acc_c[i] = last_acc;
    end
    idle(3);
    check_frame("basic", exp);
    if (out_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_cyc[i] !== acc_c[i] + 1) begin
          errors++;
          $display("FAIL basic_latency%0d: out cycle %0d required %0d", i, out_cyc[i], acc_c[i] + 1);
        end
      end
    end
    checks++;
    if (err_cnt !== 0) begin
      errors++;
      $display("FAIL basic_frame_err: pulses=%0d required 0", err_cnt);
    end
  endtask

  task automatic test_false_start();
    logic [7:0] pre[8] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] exp[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clear_mon();
    for (int i = 0; i < 8; i++) send(pre[i], 1'b0);
    for (int i = 0; i < 4; i++) send(exp[i], 1'b0);
    idle(3);
    check_frame("false_start", exp);
  endtask

  task automatic test_overlap();
    logic [7:0] exp[4] = '{8'hFF, 8'h01, 8'h02, 8'h03};
    clear_mon();
    send_marker();
    for (int i = 0; i < 4; i++) send(exp[i], 1'b0);
    idle(3);
    check_frame("overlap", exp);
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic found;
    clear_mon();
    found = 1'b0;
    fork
      begin
        send_marker();
        for (int i = 0; i < 4; i++) send(exp[i], 1'b0);
      end
      begin
        for (int n = 0; n < 40 && !found; n++) begin
          @(posedge clk); #1;
          if (m_tvalid && m_tdata == 8'h22) found = 1'b1;
        end
        if (!found) begin
          errors++; checks++;
          $display("FAIL stall_trigger: 22 never presented");
        end else begin
          m_tready = 1'b0;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 8'h22) begin
              errors++;
              $display("FAIL stall_hold%0d: s_tready=%b v=%b d=%h required 0 1 22", k, s_tready, m_tvalid, m_tdata);
            end
            @(posedge clk); #1;
          end
          m_tready = 1'b1;
        end
      end
    join
    idle(3);
    check_frame("backpressure", exp);
  endtask

  task automatic test_truncated();
    clear_mon();
    send_marker();
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    idle(3);
    checks++;
    if (out_data.size() !== 2) begin
      errors++;
      $display("FAIL trunc_count: got %0d beats required 2", out_data.size());
    end else begin
      checks++;
      if (out_data[0] !== 8'h11 || out_last[0] !== 1'b0 || out_err[0] !== 1'b0) begin
        errors++;
        $display("FAIL trunc_beat0: d=%h l=%b e=%b required 11 0 0", out_data[0], out_last[0], out_err[0]);
      end
      checks++;
      if (out_data[1] !== 8'h22 || out_last[1] !== 1'b1 || out_err[1] !== 1'b1) begin
        errors++;
        $display("FAIL trunc_beat1: d=%h l=%b e=%b required 22 1 1", out_data[1], out_last[1], out_err[1]);
      end
    end
    checks++;
    if (err_cnt !== 1) begin
      errors++;
      $display("FAIL trunc_err_pulses: got %0d required 1", err_cnt);
    end
    clear_mon();
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    idle(3);
    checks++;
    if (out_data.size() !== 0) begin
      errors++;
      $display("FAIL trunc_no_marker: got %0d beats required 0", out_data.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_marker();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    reset = 1'b1; #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: v=%b l=%b e=%b required 0 0 0", m_tvalid, m_tlast, frame_err);
    end
    @(negedge clk); reset = 1'b0;
    clear_mon();
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    idle(3);
    checks++;
    if (out_data.size() !== 0) begin
      errors++;
      $display("FAIL midreset_abandon: got %0d beats required 0", out_data.size());
    end
    clear_mon();
    send_marker();
    for (int i = 0; i < 4; i++) send(exp[i], 1'b0);
    idle(3);
    check_frame("midreset_fresh", exp);
  endtask

  initial begin
    fork
      begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
      end
    join_none
    test_reset();
    test_basic();
    test_false_start();
    test_overlap();
    test_backpressure();
    test_truncated();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
